// File: rtl/vga_timing_pkg.sv
// Purpose: shared VGA 640x480@60 raster constants and sync-window helper.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a; imported by the timing generator, pixel generator and mouse overlay.
package vga_timing_pkg;

  // Default horizontal geometry, in pixels.
  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;  // 800

  // Default vertical geometry, in lines.
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;  // 525

  // Sync pulse windows (inclusive first/last positions).
  localparam int HS_START = H_VISIBLE + H_FRONT;             // 656
  localparam int HS_END   = H_VISIBLE + H_FRONT + H_SYNC - 1; // 751
  localparam int VS_START = V_VISIBLE + V_FRONT;             // 490
  localparam int VS_END   = V_VISIBLE + V_FRONT + V_SYNC - 1; // 491

  // Both syncs are active low for this mode.
  localparam logic SYNC_ACTIVE = 1'b0;

  // True when pos lies in [first, first+len-1].
  function automatic logic in_window(logic [9:0] pos, int first, int len);
    int p;
    p = int'(pos);
    return (p >= first) && (p < first + len);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Purpose: raster interface from the timing generator to pixel consumers.
// Latency: n/a (wires only).
// Backpressure: none; consumers sample on pclk_en and cannot stall the raster.
// Signals: pclk_en, h_cnt, v_cnt, valid, hsync, vsync, line_start, frame_start, blink.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic       pclk_en;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       valid;
  logic       hsync;
  logic       vsync;
  logic       line_start;
  logic       frame_start;
  logic       blink;

  modport master (
    output pclk_en, h_cnt, v_cnt, valid, hsync, vsync,
    output line_start, frame_start, blink
  );

  modport slave (
    input pclk_en, h_cnt, v_cnt, valid, hsync, vsync,
    input line_start, frame_start, blink
  );
endinterface

// File: rtl/vga_timing_gen_pclk_div.sv
// Purpose: pixel clock-enable divider, one pclk_en pulse every CLK_DIV clocks.
// Latency: first pulse in the cycle where div reaches CLK_DIV-1 after reset release.
// Backpressure: none; free-running.
// Ports: clk, rst_n (async active low), pclk_en (decoded from the div register).
module pclk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic pclk_en
);

  generate
    if (CLK_DIV <= 1) begin : g_tied
      assign pclk_en = 1'b1;
    end else begin : g_cnt
      localparam int W = $clog2(CLK_DIV);
      localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

      logic [W-1:0] div;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          div <= '0;
        end else if (div == LAST) begin
          div <= '0;
        end else begin
          div <= div + 1'b1;
        end
      end

      assign pclk_en = (div == LAST);
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Purpose: VGA raster timing source (position, visible flag, syncs, line/frame markers, blink).
// Latency: valid/syncs aligned with h_cnt/v_cnt; one extra pixel tick when VGA_SYNC_DELAY_EN is defined.
// Backpressure: none; the raster free-runs and consumers sample on pclk_en.
// Ports: clk, rst_n (async active low), vif (vga_timing_gen_if.master).
module vga_timing_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
  input  logic              clk,
  input  logic              rst_n,
  vga_timing_gen_if.master  vif
);
  import vga_timing_pkg::*;

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_FIRST = H_VISIBLE + H_FRONT;
  localparam int VS_FIRST = V_VISIBLE + V_FRONT;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  logic       pclk_en;
  logic [9:0] h_cnt, v_cnt;
  logic [9:0] h_nxt, v_nxt;
  logic [5:0] frame_cnt;
  logic       valid_q, hsync_q, vsync_q, line_start_q, frame_start_q;
  logic       valid_nxt, hsync_nxt, vsync_nxt;

  pclk_div #(.CLK_DIV(CLK_DIV)) u_pclk_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .pclk_en (pclk_en)
  );

  // Next raster position; flags below are decoded from it so the registered
  // copies land on the same edge as the counters they describe.
  always_comb begin
    h_nxt = h_cnt + 10'd1;
    v_nxt = v_cnt;
    if (h_cnt == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end
    valid_nxt = in_window(h_nxt, 0, H_VISIBLE) && in_window(v_nxt, 0, V_VISIBLE);
    hsync_nxt = in_window(h_nxt, HS_FIRST, H_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_nxt = in_window(v_nxt, VS_FIRST, V_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  end

  // Reset parks the raster on the last position so the first tick wraps to (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt         <= H_LAST;
      v_cnt         <= V_LAST;
      frame_cnt     <= '0;
      valid_q       <= 1'b0;
      hsync_q       <= ~SYNC_ACTIVE;
      vsync_q       <= ~SYNC_ACTIVE;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (pclk_en) begin
      h_cnt         <= h_nxt;
      v_cnt         <= v_nxt;
      valid_q       <= valid_nxt;
      hsync_q       <= hsync_nxt;
      vsync_q       <= vsync_nxt;
      line_start_q  <= (h_nxt == '0);
      frame_start_q <= (h_nxt == '0) && (v_nxt == '0);
      if ((h_nxt == '0) && (v_nxt == '0)) begin
        frame_cnt <= frame_cnt + 6'd1;
      end
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  // One more pixel tick on valid/syncs for sources with a registered memory read.
  logic valid_d, hsync_d, vsync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_d <= 1'b0;
      hsync_d <= ~SYNC_ACTIVE;
      vsync_d <= ~SYNC_ACTIVE;
    end else if (pclk_en) begin
      valid_d <= valid_q;
      hsync_d <= hsync_q;
      vsync_d <= vsync_q;
    end
  end

  assign vif.valid = valid_d;
  assign vif.hsync = hsync_d;
  assign vif.vsync = vsync_d;
`else
  assign vif.valid = valid_q;
  assign vif.hsync = hsync_q;
  assign vif.vsync = vsync_q;
`endif

  assign vif.pclk_en     = pclk_en;
  assign vif.h_cnt       = h_cnt;
  assign vif.v_cnt       = v_cnt;
  assign vif.line_start  = line_start_q;
  assign vif.frame_start = frame_start_q;
  assign vif.blink       = frame_cnt[5];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Purpose: randomized-reset scoreboard bench for vga_timing_gen on a reduced raster.
// Latency: expected per-tick state derived from elapsed clocks since reset release.
// Backpressure: n/a.
module tb_vga_timing_gen;

  localparam int D  = 4;
  localparam int HV = 10, HF = 2, HS = 3, HB = 3;
  localparam int VV = 6,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;  // 18
  localparam int VT = VV + VF + VS + VB;  // 11
  localparam int FT = HT * VT;            // ticks per frame

  typedef struct {
    int cyc;
    int h;
    int v;
    int valid;
    int hs;
    int vs;
    int ls;
    int fs;
    int bl;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   n = 0;        // clocks since reset release, as seen by stimulus
  int   mon_cyc = 0;  // clocks since reset release, as seen by monitor
  exp_t sb[$];

  vga_timing_gen_if vif ();

  vga_timing_gen #(
    .CLK_DIV(D),
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vif   (vif)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, mon_cyc);
    end
  endtask

  // Visible flag and syncs for the raster after k ticks (k=0: reset state).
  function automatic void sync_at(int k, output int valid, output int hs, output int vs);
    int p, h, v;
    if (k == 0) begin
      valid = 0; hs = 1; vs = 1;
    end else begin
      p = (k - 1) % FT;
      h = p % HT;
      v = p / HT;
      valid = (h < HV && v < VV) ? 1 : 0;
      hs = (h >= HV + HF && h < HV + HF + HS) ? 0 : 1;
      vs = (v >= VV + VF && v < VV + VF + VS) ? 0 : 1;
    end
  endfunction

  // Raster state visible after k pixel ticks since reset release.
  function automatic exp_t model(int k);
    exp_t e;
    int p, f;
    if (k == 0) begin
      e.h = HT - 1; e.v = VT - 1; f = 0;
      e.ls = 0; e.fs = 0;
    end else begin
      p = (k - 1) % FT;
      e.h = p % HT;
      e.v = p / HT;
      f = ((k - 1) / FT + 1) % 64;
      e.ls = (e.h == 0) ? 1 : 0;
      e.fs = (e.h == 0 && e.v == 0) ? 1 : 0;
    end
    e.bl = (f / 32) % 2;
`ifdef VGA_SYNC_DELAY_EN
    sync_at((k == 0) ? 0 : k - 1, e.valid, e.hs, e.vs);
`else
    sync_at(k, e.valid, e.hs, e.vs);
`endif
    e.cyc = 0;
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mon_cyc <= 0;
    else        mon_cyc <= mon_cyc + 1;
  end

  // Monitor: every pclk_en cycle pops one expectation and compares the raster.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && vif.pclk_en) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tick: pclk_en high at cyc %0d, expected low", mon_cyc);
      end else begin
        e = sb.pop_front();
        chk("tick_cyc",    mon_cyc,               e.cyc);
        chk("h_cnt",       int'(vif.h_cnt),       e.h);
        chk("v_cnt",       int'(vif.v_cnt),       e.v);
        chk("valid",       int'(vif.valid),       e.valid);
        chk("hsync",       int'(vif.hsync),       e.hs);
        chk("vsync",       int'(vif.vsync),       e.vs);
        chk("line_start",  int'(vif.line_start),  e.ls);
        chk("frame_start", int'(vif.frame_start), e.fs);
        chk("blink",       int'(vif.blink),       e.bl);
      end
    end
  end

  // Advance ncyc clocks, queueing the expected raster for each expected tick.
  task automatic run(int ncyc);
    exp_t e;
    repeat (ncyc) begin
      @(posedge clk);
      #1;
      n++;
      if (n % D == D - 1) begin
        if (sb.size() != 0) begin
          checks++;
          errors++;
          $display("FAIL missed_tick: %0d expected ticks not seen, expected 0 at cyc %0d", sb.size(), n);
          sb.delete();
        end
        e = model(n / D);
        e.cyc = n;
        sb.push_back(e);
      end
    end
  endtask

  // Outputs must return to reset values as soon as rst_n falls.
  task automatic check_reset_values();
    chk("rst_h_cnt",       int'(vif.h_cnt),       HT - 1);
    chk("rst_v_cnt",       int'(vif.v_cnt),       VT - 1);
    chk("rst_valid",       int'(vif.valid),       0);
    chk("rst_hsync",       int'(vif.hsync),       1);
    chk("rst_vsync",       int'(vif.vsync),       1);
    chk("rst_line_start",  int'(vif.line_start),  0);
    chk("rst_frame_start", int'(vif.frame_start), 0);
    chk("rst_blink",       int'(vif.blink),       0);
    chk("rst_pclk_en",     int'(vif.pclk_en),     0);
  endtask

  task automatic do_reset(int hold);
    rst_n = 1'b0;
    #1;
    check_reset_values();
    sb.delete();
    repeat (hold) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    rst_n = 1'b1;
    n = 0;

    // 65 full frames plus a little: covers blink rising at frame 32 and
    // frame_cnt wrapping to 0 at the 64th frame_start.
    run(D * (65 * FT + 5));

    // Random mid-frame resets of 1..3 clocks; each restart is rechecked from tick 0.
    for (int s = 0; s < 4; s++) begin
      run($urandom_range(60, 3000));
      do_reset($urandom_range(1, 3));
    end
    run(D * FT + 10);

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected ticks not seen, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
